// File: rtl/tail_light_seq.sv
// Rear-lamp sequencer: arbitrates brake/turn/hazard and sweeps or flashes six lamps.
// Latency: outputs are decoded from registers, 1 clk after inputs are sampled.
// Backpressure: none; free-running, and inputs are sampled every clk.
module tail_light_seq #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brake,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       hazard,
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN_L = 2'd1,
        TURN_R = 2'd2,
        HAZARD = 2'd3
    } state_t;

    state_t        state, state_nxt, req;
    logic [1:0]    step, step_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          brake_q;
    logic          tick_q, tick_nxt;

    // Sequencer registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            step    <= 2'd0;
            cnt     <= '0;
            brake_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            cnt     <= cnt_nxt;
            brake_q <= brake;
            tick_q  <= tick_nxt;
        end
    end

    // Arbitrate requests, then either restart on a change or advance the prescaler/step.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;

        if (hazard || (turn_left && turn_right)) begin
            req = HAZARD;
        end else if (turn_left) begin
            req = TURN_L;
        end else if (turn_right) begin
            req = TURN_R;
        end else begin
            req = IDLE;
        end

        if (req != state) begin
            state_nxt = req;
            step_nxt  = 2'd0;
            cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            case (state)
                TURN_L, TURN_R: begin
                    step_nxt = step + 2'd1;
                    tick_nxt = 1'b1;
                end
                HAZARD: begin
                    step_nxt = {1'b0, ~step[0]};
                    tick_nxt = 1'b1;
                end
                default: step_nxt = 2'd0;
            endcase
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Lamp decode: the sweeping side shows the turn pattern, then hazard, then brake.
    always_comb begin
        logic [2:0] turn_pat;
        logic [2:0] haz_pat;
        logic [2:0] idle_pat;

        case (step)
            2'd0:    turn_pat = 3'b001;
            2'd1:    turn_pat = 3'b011;
            2'd2:    turn_pat = 3'b111;
            default: turn_pat = 3'b000;
        endcase
        haz_pat  = (step == 2'd0) ? 3'b111 : 3'b000;
        idle_pat = brake_q ? 3'b111 : 3'b000;

        lamp_l = idle_pat;
        lamp_r = idle_pat;
        case (state)
            TURN_L: lamp_l = turn_pat;
            TURN_R: lamp_r = turn_pat;
            HAZARD: begin
                lamp_l = haz_pat;
                lamp_r = haz_pat;
            end
            default: ;
        endcase

        mode      = {state != IDLE, brake_q};
        step_tick = tick_q;
    end

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: directed scenarios plus randomized traffic.
// Latency: expected outputs are queued before each edge and compared 1 ns after it.
// Backpressure: not applicable; one scoreboard entry per clock.
module tb_tail_light_seq;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       brake = 1'b0;
    logic       turn_left = 1'b0;
    logic       turn_right = 1'b0;
    logic       hazard = 1'b0;
    logic [2:0] lamp_l, lamp_r;
    logic [1:0] mode;
    logic       step_tick;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    typedef struct packed {
        logic [2:0] l;
        logic [2:0] r;
        logic [1:0] m;
        logic       t;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 idle, 1 left, 2 right, 3 hazard.
    int m_state, m_step, m_cnt;
    logic m_bq, m_tick;

    tail_light_seq #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst), .brake(brake), .turn_left(turn_left),
        .turn_right(turn_right), .hazard(hazard), .lamp_l(lamp_l),
        .lamp_r(lamp_r), .mode(mode), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_step = 0; m_cnt = 0; m_bq = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_clock();
        int req;
        if (hazard || (turn_left && turn_right)) req = 3;
        else if (turn_left) req = 1;
        else if (turn_right) req = 2;
        else req = 0;
        m_tick = 1'b0;
        if (req != m_state) begin
            m_state = req; m_step = 0; m_cnt = 0;
        end else if (m_cnt == TICK_DIV - 1) begin
            m_cnt = 0;
            if (m_state == 1 || m_state == 2) begin
                m_step = (m_step + 1) % 4; m_tick = 1'b1;
            end else if (m_state == 3) begin
                m_step = (m_step + 1) % 2; m_tick = 1'b1;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_bq = brake;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [2:0] sweep, base;
        case (m_step)
            0: sweep = 3'b001;
            1: sweep = 3'b011;
            2: sweep = 3'b111;
            default: sweep = 3'b000;
        endcase
        if (m_state == 3) base = (m_step == 0) ? 3'b111 : 3'b000;
        else base = m_bq ? 3'b111 : 3'b000;
        e.l = (m_state == 1) ? sweep : base;
        e.r = (m_state == 2) ? sweep : base;
        e.m = {m_state != 0, m_bq};
        e.t = m_tick;
        return e;
    endfunction

    // Advance one clock: queue the model's prediction, then compare after the edge.
    task automatic cycle();
        exp_t e;
        model_clock();
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        ecount++;
        e = sb.pop_front();
        checks++;
        if (lamp_l !== e.l) begin
            errors++; $display("FAIL sb_lamp_l e%0d: got %b expected %b", ecount, lamp_l, e.l);
        end
        checks++;
        if (lamp_r !== e.r) begin
            errors++; $display("FAIL sb_lamp_r e%0d: got %b expected %b", ecount, lamp_r, e.r);
        end
        checks++;
        if (mode !== e.m) begin
            errors++; $display("FAIL sb_mode e%0d: got %b expected %b", ecount, mode, e.m);
        end
        checks++;
        if (step_tick !== e.t) begin
            errors++; $display("FAIL sb_tick e%0d: got %b expected %b", ecount, step_tick, e.t);
        end
    endtask

    task automatic do_reset();
        brake = 0; turn_left = 0; turn_right = 0; hazard = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ecount = 0;
    endtask

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
        // Intentionally unused helper avoided; directed checks are inline below.
    endtask

    task automatic test_reset();
        do_reset();
        turn_left = 1;
        for (int i = 0; i < 6; i++) cycle();
        rst = 1'b1;
        #1;
        checks++;
        if ({lamp_l, lamp_r, mode, step_tick} !== 9'd0) begin
            errors++;
            $display("FAIL reset_async: got l=%b r=%b m=%b t=%b expected all 0",
                     lamp_l, lamp_r, mode, step_tick);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({lamp_l, lamp_r, mode, step_tick} !== 9'd0) begin
            errors++;
            $display("FAIL reset_held: got l=%b r=%b m=%b t=%b expected all 0",
                     lamp_l, lamp_r, mode, step_tick);
        end
        rst = 1'b0;
        turn_left = 0;
        ecount = 0;
    endtask

    task automatic test_turn_left();
        do_reset();
        turn_left = 1;
        for (int i = 0; i < 18; i++) begin
            cycle();
            if (ecount == 1 || ecount == 5 || ecount == 9 || ecount == 13 || ecount == 17) begin
                logic [2:0] want;
                case (ecount)
                    1, 17:   want = 3'b001;
                    5:       want = 3'b011;
                    9:       want = 3'b111;
                    default: want = 3'b000;
                endcase
                checks++;
                if (lamp_l !== want || lamp_r !== 3'b000 || mode !== 2'b10) begin
                    errors++;
                    $display("FAIL turn_left e%0d: got l=%b r=%b m=%b expected l=%b r=000 m=10",
                             ecount, lamp_l, lamp_r, mode, want);
                end
            end
            if (ecount == 5 || ecount == 6) begin
                checks++;
                if (step_tick !== (ecount == 5)) begin
                    errors++;
                    $display("FAIL turn_left_tick e%0d: got %b expected %b",
                             ecount, step_tick, ecount == 5);
                end
            end
        end
    endtask

    task automatic test_brake_during_turn();
        do_reset();
        turn_right = 1;
        for (int i = 0; i < 10; i++) begin
            if (ecount == 3) brake = 1;
            if (ecount == 6) brake = 0;
            cycle();
            if (ecount >= 2 && ecount <= 8) begin
                logic in_b;
                in_b = (ecount >= 4 && ecount <= 6);
                checks++;
                if (lamp_l !== (in_b ? 3'b111 : 3'b000) || mode !== {1'b1, in_b}) begin
                    errors++;
                    $display("FAIL brake_turn e%0d: got l=%b m=%b expected l=%b m=1%b",
                             ecount, lamp_l, mode, in_b ? 3'b111 : 3'b000, in_b);
                end
            end
            if (ecount == 5) begin
                checks++;
                if (lamp_r !== 3'b011) begin
                    errors++; $display("FAIL brake_turn_sweep e5: got %b expected 011", lamp_r);
                end
            end
        end
    endtask

    task automatic test_hazard();
        do_reset();
        turn_left = 1; turn_right = 1;
        for (int i = 0; i < 14; i++) begin
            if (ecount == 10) brake = 1;
            cycle();
            if (ecount == 1 || ecount == 5 || ecount == 9 || ecount == 13) begin
                logic [2:0] want;
                want = (ecount == 5 || ecount == 13) ? 3'b000 : 3'b111;
                checks++;
                if (lamp_l !== want || lamp_r !== want || mode !== {1'b1, ecount > 10}) begin
                    errors++;
                    $display("FAIL hazard e%0d: got l=%b r=%b m=%b expected l=r=%b m=1%b",
                             ecount, lamp_l, lamp_r, mode, want, ecount > 10);
                end
            end
        end
    endtask

    task automatic test_switch_side();
        do_reset();
        turn_left = 1;
        for (int i = 0; i < 14; i++) begin
            if (ecount == 9) begin
                turn_left = 0; turn_right = 1;
            end
            cycle();
            if (ecount == 9) begin
                checks++;
                if (lamp_l !== 3'b111) begin
                    errors++; $display("FAIL switch_pre e9: got %b expected 111", lamp_l);
                end
            end
            if (ecount == 10 || ecount == 14) begin
                logic [2:0] want;
                want = (ecount == 10) ? 3'b001 : 3'b011;
                checks++;
                if (lamp_l !== 3'b000 || lamp_r !== want) begin
                    errors++;
                    $display("FAIL switch e%0d: got l=%b r=%b expected l=000 r=%b",
                             ecount, lamp_l, lamp_r, want);
                end
            end
        end
    endtask

    task automatic test_brake_only();
        do_reset();
        brake = 1;
        for (int i = 0; i < 6; i++) begin
            if (ecount == 3) brake = 0;
            cycle();
            begin
                logic on;
                on = (ecount <= 3);
                checks++;
                if (lamp_l !== {3{on}} || lamp_r !== {3{on}} || mode !== {1'b0, on}) begin
                    errors++;
                    $display("FAIL brake_only e%0d: got l=%b r=%b m=%b expected %b m=0%b",
                             ecount, lamp_l, lamp_r, mode, {3{on}}, on);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) turn_left = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) turn_right = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) hazard = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) brake = $urandom_range(0, 1);
            cycle();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_turn_left();
        test_brake_during_turn();
        test_hazard();
        test_switch_side();
        test_brake_only();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
